// File: rtl/multi_axis_step_generator.sv
// multi_axis_step_generator
//   N-axis step/direction pulse generator. Takes one coordinated move command
//   (per-axis period, step count, direction), holds DIR stable for DIR_SETUP
//   cycles, then emits counted step pulses on every axis concurrently and
//   pulses `done` when the last axis finishes.
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   enable       0 pauses SETUP/RUN (all counters and outputs hold)
//   abort        cancels any move, back to IDLE without a done pulse
//   cmd_valid    move command valid; accepted when cmd_ready=1
//   cmd_ready    high only in IDLE
//   cmd_dir      per-axis direction
//   cmd_period   per-axis step period, axis i at [i*DIV_WIDTH +: DIV_WIDTH]
//   cmd_steps    per-axis step count, axis i at [i*STEP_WIDTH +: STEP_WIDTH]
//   step_clk     step pulses, PULSE_WIDTH cycles high
//   dir          direction outputs, updated the cycle after accept
//   busy         move in progress
//   done         one-cycle pulse on normal completion
module multi_axis_step_generator #(
  parameter int unsigned NUM_AXES    = 2,
  parameter int unsigned DIV_WIDTH   = 32,
  parameter int unsigned STEP_WIDTH  = 16,
  parameter int unsigned PULSE_WIDTH = 50,
  parameter int unsigned DIR_SETUP   = 100
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           abort,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [NUM_AXES-1:0]            cmd_dir,
  input  logic [NUM_AXES*DIV_WIDTH-1:0]  cmd_period,
  input  logic [NUM_AXES*STEP_WIDTH-1:0] cmd_steps,
  output logic [NUM_AXES-1:0]            step_clk,
  output logic [NUM_AXES-1:0]            dir,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

  localparam int unsigned          SET_W      = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
  localparam logic [SET_W-1:0]     SETUP_LAST = SET_W'(DIR_SETUP - 1);
  localparam logic [DIV_WIDTH-1:0] PW_V       = DIV_WIDTH'(PULSE_WIDTH);
  localparam logic [DIV_WIDTH-1:0] MIN_PERIOD = DIV_WIDTH'(PULSE_WIDTH + 1);

  state_t                  state_q, state_d;
  logic [SET_W-1:0]        setup_q, setup_d;
  logic [DIV_WIDTH-1:0]    cnt_q [NUM_AXES];
  logic [DIV_WIDTH-1:0]    cnt_d [NUM_AXES];
  logic [DIV_WIDTH-1:0]    eff_q [NUM_AXES];
  logic [DIV_WIDTH-1:0]    eff_d [NUM_AXES];
  logic [STEP_WIDTH-1:0]   rem_q [NUM_AXES];
  logic [STEP_WIDTH-1:0]   rem_d [NUM_AXES];
  logic [NUM_AXES-1:0]     dir_d, step_d;
  logic                    all_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // step_d is the registered value of step_clk for the *next* cycle, so it is
  // derived from the next counter values; this is what makes the first edge
  // appear on the very first RUN cycle.
  always_comb begin
    state_d  = state_q;
    setup_d  = setup_q;
    dir_d    = dir;
    step_d   = step_clk;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_AXES; i++) begin
      cnt_d[i] = cnt_q[i];
      rem_d[i] = rem_q[i];
      eff_d[i] = eff_q[i];
    end

    if (abort) begin
      state_d = S_IDLE;
      step_d  = '0;
      setup_d = '0;
      for (int unsigned i = 0; i < NUM_AXES; i++) begin
        cnt_d[i] = '0;
        rem_d[i] = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            dir_d   = cmd_dir;
            setup_d = '0;
            for (int unsigned i = 0; i < NUM_AXES; i++) begin
              eff_d[i] = (cmd_period[i*DIV_WIDTH +: DIV_WIDTH] < MIN_PERIOD)
                         ? MIN_PERIOD : cmd_period[i*DIV_WIDTH +: DIV_WIDTH];
              rem_d[i] = cmd_steps[i*STEP_WIDTH +: STEP_WIDTH];
              cnt_d[i] = '0;
              if (cmd_steps[i*STEP_WIDTH +: STEP_WIDTH] != '0) all_zero = 1'b0;
            end
            state_d = all_zero ? S_DONE : S_SETUP;
          end
        end

        S_SETUP: begin
          if (enable) begin
            if (setup_q == SETUP_LAST) begin
              state_d = S_RUN;
              for (int unsigned i = 0; i < NUM_AXES; i++)
                step_d[i] = (rem_q[i] != '0);
            end else begin
              setup_d = setup_q + 1'b1;
            end
          end
        end

        S_RUN: begin
          if (enable) begin
            for (int unsigned i = 0; i < NUM_AXES; i++) begin
              if (rem_q[i] != '0) begin
                if (cnt_q[i] == eff_q[i] - 1'b1) begin
                  cnt_d[i] = '0;
                  rem_d[i] = rem_q[i] - 1'b1;
                end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
                end
              end
              step_d[i] = (rem_d[i] != '0) && (cnt_d[i] < PW_V);
              if (rem_d[i] != '0) all_zero = 1'b0;
            end
            if (all_zero) state_d = S_DONE;
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
          step_d  = '0;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      setup_q   <= '0;
      step_clk  <= '0;
      dir       <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int unsigned i = 0; i < NUM_AXES; i++) begin
        cnt_q[i] <= '0;
        rem_q[i] <= '0;
        eff_q[i] <= '0;
      end
    end else begin
      setup_q   <= setup_d;
      step_clk  <= step_d;
      dir       <= dir_d;
      cmd_ready <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE);
      done      <= (state_d == S_DONE);
      for (int unsigned i = 0; i < NUM_AXES; i++) begin
        cnt_q[i] <= cnt_d[i];
        rem_q[i] <= rem_d[i];
        eff_q[i] <= eff_d[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_axis_step_generator.sv
module tb_multi_axis_step_generator;

  localparam int NA = 2;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int PW = 2;
  localparam int DS = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b1;
  logic              abort = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [NA-1:0]     cmd_dir = '0;
  logic [NA*DW-1:0]  cmd_period = '0;
  logic [NA*SW-1:0]  cmd_steps = '0;
  logic [NA-1:0]     step_clk;
  logic [NA-1:0]     dir;
  logic              busy;
  logic              done;

  multi_axis_step_generator #(
    .NUM_AXES(NA), .DIV_WIDTH(DW), .STEP_WIDTH(SW),
    .PULSE_WIDTH(PW), .DIR_SETUP(DS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_period(cmd_period), .cmd_steps(cmd_steps),
    .step_clk(step_clk), .dir(dir), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int pc [NA];
  logic [NA-1:0] prev_step = '0;

  // Reference model: a move is described by the number of enabled cycles u
  // elapsed since accept; step outputs follow from plain arithmetic on u.
  bit            m_active = 0;
  bit            m_done = 0;
  int            m_u = 0;
  int            m_T = 0;
  int            m_steps [NA];
  int            m_eff [NA];
  logic [NA-1:0] m_dir = '0;

  typedef struct {
    int p0; int p1; int s0; int s1; logic [1:0] d;
    int lat; int n0; int n1;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NA-1:0] exp_step();
    logic [NA-1:0] s;
    int r;
    s = '0;
    r = m_u - DS;
    for (int i = 0; i < NA; i++)
      s[i] = m_active && (r >= 0) && (r < m_steps[i] * m_eff[i]) && ((r % m_eff[i]) < PW);
    return s;
  endfunction

  task automatic model_edge();
    if (abort) begin
      m_active = 0;
      m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (cmd_valid) begin
        m_dir = cmd_dir;
        m_T = 0;
        for (int i = 0; i < NA; i++) begin
          int p;
          p = int'(cmd_period[i*DW +: DW]);
          m_eff[i] = (p < PW + 1) ? PW + 1 : p;
          m_steps[i] = int'(cmd_steps[i*SW +: SW]);
          if (m_steps[i] * m_eff[i] > m_T) m_T = m_steps[i] * m_eff[i];
        end
        m_u = 0;
        if (m_T == 0) m_done = 1;
        else m_active = 1;
      end
    end else if (enable) begin
      m_u++;
      if (m_u == DS + m_T) begin
        m_active = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_u = 0; m_T = 0; m_dir = '0;
  endtask

  task automatic check_all();
    chk("step_clk", int'(step_clk), int'(exp_step()));
    chk("dir", int'(dir), int'(m_dir));
    chk("busy", int'(busy), int'(m_active || m_done));
    chk("done", int'(done), int'(m_done));
    chk("cmd_ready", int'(cmd_ready), int'(!m_active && !m_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_all();
    for (int i = 0; i < NA; i++)
      if (step_clk[i] && !prev_step[i]) pc[i]++;
    prev_step = step_clk;
  endtask

  task automatic set_cmd(input int p0, input int p1, input int s0, input int s1,
                         input logic [1:0] d);
    cmd_period = {DW'(p1), DW'(p0)};
    cmd_steps  = {SW'(s1), SW'(s0)};
    cmd_dir    = d;
  endtask

  task automatic issue(input int p0, input int p1, input int s0, input int s1,
                       input logic [1:0] d);
    set_cmd(p0, p1, s0, s1, d);
    cmd_valid = 1'b1;
    for (int i = 0; i < NA; i++) pc[i] = 0;
    tick();
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic run_to_done(input string name, input int exp_lat,
                             input int e0, input int e1);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk({name, "_done_latency"}, (done === 1'b1) ? (cyc - acc_cyc) : -1, exp_lat);
    chk({name, "_pulses_axis0"}, pc[0], e0);
    chk({name, "_pulses_axis1"}, pc[1], e1);
    tick();
  endtask

  initial begin
    // Latencies count ticks from the accept edge to the visible done pulse:
    // DIR_SETUP + max(steps*eff_period), or 0 for an all-zero move.
    tbl[0] = '{p0:10, p1:0,  s0:5,  s1:0, d:2'b01, lat:53, n0:5,  n1:0};
    tbl[1] = '{p0:7,  p1:3,  s0:2,  s1:4, d:2'b10, lat:17, n0:2,  n1:4};
    tbl[2] = '{p0:0,  p1:1,  s0:3,  s1:2, d:2'b11, lat:12, n0:3,  n1:2};
    tbl[3] = '{p0:0,  p1:0,  s0:0,  s1:0, d:2'b01, lat:0,  n0:0,  n1:0};
    tbl[4] = '{p0:4,  p1:5,  s0:15, s1:1, d:2'b00, lat:63, n0:15, n1:1};
    tbl[5] = '{p0:2,  p1:3,  s0:1,  s1:1, d:2'b10, lat:6,  n0:1,  n1:1};

    for (int i = 0; i < NA; i++) begin pc[i] = 0; m_steps[i] = 0; m_eff[i] = PW + 1; end

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_step_clk", int'(step_clk), 0);
    chk("reset_dir", int'(dir), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    rst_n = 1'b1;
    tick();

    // Table-driven moves
    for (int v = 0; v < 6; v++) begin
      issue(tbl[v].p0, tbl[v].p1, tbl[v].s0, tbl[v].s1, tbl[v].d);
      chk("accept_dir", int'(dir), int'(tbl[v].d));
      run_to_done($sformatf("vec%0d", v), tbl[v].lat, tbl[v].n0, tbl[v].n1);
      tick();
    end

    // Pause in the middle of the first high pulse: stretched by 20 cycles
    issue(10, 0, 5, 0, 2'b01);
    for (int n = 0; n < 20 && !step_clk[0]; n++) tick();
    chk("pause_first_edge_at", cyc - acc_cyc, DS);
    enable = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("pause_hold_high", int'(step_clk[0]), 1);
    end
    enable = 1'b1;
    run_to_done("pause", 53 + 20, 5, 0);

    // Abort mid-RUN while both axes are high
    issue(10, 10, 5, 5, 2'b11);
    repeat (13) tick();
    chk("abort_pre_step", int'(step_clk), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_step", int'(step_clk), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_dir_held", int'(dir), 3);
    repeat (4) tick();

    // Abort beats a simultaneous command
    set_cmd(5, 5, 1, 1, 2'b00);
    abort = 1'b1;
    cmd_valid = 1'b1;
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    chk("abort_vs_cmd_busy", int'(busy), 0);
    chk("abort_vs_cmd_dir", int'(dir), 3);

    // cmd_valid held through a move: next command taken right after done
    issue(7, 3, 2, 4, 2'b10);
    set_cmd(0, 0, 1, 0, 2'b01);
    cmd_valid = 1'b1;
    run_to_done("held_a", 17, 2, 4);
    chk("held_idle_ready", int'(cmd_ready), 1);
    chk("held_idle_busy", int'(busy), 0);
    for (int i = 0; i < NA; i++) pc[i] = 0;
    tick();
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    chk("held_b_busy", int'(busy), 1);
    chk("held_b_dir", int'(dir), 1);
    run_to_done("held_b", 6, 1, 0);

    // Asynchronous reset in the middle of a move
    issue(6, 4, 4, 4, 2'b11);
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_step", int'(step_clk), 0);
    chk("async_rst_dir", int'(dir), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_ready", int'(cmd_ready), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      enable    = ($urandom_range(0, 4) != 0);
      abort     = ($urandom_range(0, 149) == 0);
      cmd_valid = ($urandom_range(0, 7) == 0);
      set_cmd($urandom_range(0, 12), $urandom_range(0, 12),
              ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 5),
              $urandom_range(0, 5), 2'($urandom_range(0, 3)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
